// File: rtl/lz4_pkg.sv
// ---------------------------------------------------------------------------
// lz4_pkg
// Shared types and constants for the LZ4 block sequence parser.
//   - lz4_state_t   : parser FSM states
//   - LZ4_MINMATCH  : implicit minimum match length added to every match
//   - LZ4_NIB_EXT   : token nibble value that announces extension bytes
//   - LZ4_EXT_CONT  : extension byte value that announces another ext byte
//   - ERRCHK_EN     : 1 when LZ4_PARSE_ERRCHK_EN is defined (error checking,
//                     saturating length arithmetic), 0 otherwise (no err,
//                     wrapping length arithmetic)
// ---------------------------------------------------------------------------
package lz4_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_LEN_W  = 16;
    localparam int DEF_OFF_W  = 16;

    localparam int         LZ4_MINMATCH = 4;
    localparam logic [3:0] LZ4_NIB_EXT  = 4'hF;
    localparam logic [7:0] LZ4_EXT_CONT = 8'hFF;

`ifdef LZ4_PARSE_ERRCHK_EN
    localparam bit ERRCHK_EN = 1'b1;
`else
    localparam bit ERRCHK_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_LIT_EXT,
        ST_LITERAL,
        ST_OFF_LO,
        ST_OFF_HI,
        ST_MLEN_EXT,
        ST_MATCH,
        ST_DONE
    } lz4_state_t;

endpackage

// File: rtl/lz4_len_accum.sv
// ---------------------------------------------------------------------------
// lz4_len_accum
// Length accumulator shared by the literal-length and match-length fields
// (the two fields are never being decoded at the same time).
//   clk, rst_n : clock, synchronous active-low reset
//   load, nib  : load the 4-bit token nibble as the new length
//   add        : add byte_in to the length (saturating when
//                LZ4_PARSE_ERRCHK_EN is defined, wrapping otherwise)
//   dec        : decrement the length by one (caller guarantees len != 0)
//   byte_in    : current extension byte
//   len        : accumulated length
//   cont       : byte_in is 255, i.e. another extension byte follows
//   carry      : adding byte_in now would overflow LEN_W bits
// ---------------------------------------------------------------------------
module lz4_len_accum
    import lz4_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [3:0]        nib,
    input  logic              add,
    input  logic              dec,
    input  logic [WORD_W-1:0] byte_in,
    output logic [LEN_W-1:0]  len,
    output logic              cont,
    output logic              carry
);

    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W:0]   sum;

    assign sum   = {1'b0, len_reg} + {{(LEN_W + 1 - WORD_W){1'b0}}, byte_in};
    assign carry = sum[LEN_W];
    assign cont  = (byte_in == WORD_W'(LZ4_EXT_CONT));
    assign len   = len_reg;

    always_comb begin
        len_next = len_reg;
        if (load) begin
            len_next = {{(LEN_W - 4){1'b0}}, nib};
        end else if (add) begin
            // Saturate to all-ones on overflow only when error checking is on.
            len_next = (ERRCHK_EN && carry) ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
        end else if (dec) begin
            len_next = len_reg - {{(LEN_W - 1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_reg <= '0;
        end else begin
            len_reg <= len_next;
        end
    end

endmodule

// File: rtl/lz4_seq_parser.sv
// ---------------------------------------------------------------------------
// lz4_seq_parser
// Decodes LZ4 block sequences (token, literal-length ext, literals, 16-bit
// LE offset, match-length ext) from a byte buffer with one-cycle read
// latency, emitting a literal byte stream and (offset, length) match cmds.
// Optional macro LZ4_PARSE_ERRCHK_EN: enables the sticky err flag (offset 0,
// length saturation, truncation) and saturating length arithmetic.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   blk_start, blk_len      start pulse (IDLE only), block length in bytes
//   in_data, in_exists      buffer byte (valid cycle after in_rd), not-empty
//   in_rd                   buffer read request
//   lit_valid/data/ready    literal byte stream
//   match_valid/off/len/ready  match command (len includes MINMATCH)
//   busy, blk_done, err     status
// ---------------------------------------------------------------------------
module lz4_seq_parser
    import lz4_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int OFF_W  = DEF_OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blk_start,
    input  logic [LEN_W-1:0]  blk_len,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_exists,
    output logic              in_rd,
    output logic              lit_valid,
    output logic [WORD_W-1:0] lit_data,
    input  logic              lit_ready,
    output logic              match_valid,
    output logic [OFF_W-1:0]  match_off,
    output logic [LEN_W-1:0]  match_len,
    input  logic              match_ready,
    output logic              busy,
    output logic              blk_done,
    output logic              err
);

    lz4_state_t        state_reg, state_next;
    logic [LEN_W-1:0]  remaining_reg;
    logic              rd_pend_reg;
    logic              hold_valid_reg;
    logic [WORD_W-1:0] hold_data_reg;
    logic [WORD_W-1:0] off_lo_reg;
    logic [WORD_W-1:0] off_hi_reg;
    logic [3:0]        mnib_reg;
    logic              err_reg;

    logic              byte_avail;
    logic [WORD_W-1:0] byte_cur;
    logic              trunc;
    logic              active;
    logic              consume;
    logic              off_lo_load, off_hi_load, mnib_load;
    logic              err_set;
    logic              acc_load, acc_add, acc_dec;
    logic [3:0]        acc_nib;
    logic [LEN_W-1:0]  acc_len;
    logic              acc_cont, acc_carry;
    logic [LEN_W:0]    mlen_sum;

    // A byte arriving from an issued read is usable in the cycle it lands,
    // so a read in flight counts as "available"; the holding register only
    // keeps it when the FSM does not consume it immediately.
    assign byte_avail = hold_valid_reg | rd_pend_reg;
    assign byte_cur   = hold_valid_reg ? hold_data_reg : in_data;
    assign trunc      = !byte_avail && (remaining_reg == '0);
    assign active     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign busy       = (state_reg != ST_IDLE);
    assign mlen_sum   = {1'b0, acc_len} + (LEN_W + 1)'(LZ4_MINMATCH);

    // Refill the slot in the same cycle it is emptied for one byte per cycle;
    // no new reads once the block is about to end.
    assign in_rd = active && in_exists && (remaining_reg != '0) &&
                   (!byte_avail || consume) && (state_next != ST_DONE);

    assign lit_data  = lit_valid ? byte_cur : '0;
    assign match_off = match_valid ? OFF_W'({off_hi_reg, off_lo_reg}) : '0;
    assign match_len = match_valid ? mlen_sum[LEN_W-1:0] : '0;

    lz4_len_accum #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_len_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (acc_load),
        .nib     (acc_nib),
        .add     (acc_add),
        .dec     (acc_dec),
        .byte_in (byte_cur),
        .len     (acc_len),
        .cont    (acc_cont),
        .carry   (acc_carry)
    );

    always_comb begin
        state_next  = state_reg;
        consume     = 1'b0;
        acc_load    = 1'b0;
        acc_nib     = 4'd0;
        acc_add     = 1'b0;
        acc_dec     = 1'b0;
        off_lo_load = 1'b0;
        off_hi_load = 1'b0;
        mnib_load   = 1'b0;
        err_set     = 1'b0;
        lit_valid   = 1'b0;
        match_valid = 1'b0;
        blk_done    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (blk_start) state_next = ST_TOKEN;
            end
            ST_TOKEN: begin
                if (byte_avail) begin
                    consume   = 1'b1;
                    acc_load  = 1'b1;
                    acc_nib   = byte_cur[7:4];
                    mnib_load = 1'b1;
                    if (byte_cur[7:4] == LZ4_NIB_EXT)  state_next = ST_LIT_EXT;
                    else if (byte_cur[7:4] != 4'd0)    state_next = ST_LITERAL;
                    else if (remaining_reg == '0)      state_next = ST_DONE;
                    else                               state_next = ST_OFF_LO;
                end else if (trunc) begin
                    // Clean end of block (or empty block).
                    state_next = ST_DONE;
                end
            end
            ST_LIT_EXT: begin
                if (byte_avail) begin
                    consume = 1'b1;
                    acc_add = 1'b1;
                    if (ERRCHK_EN && acc_carry) begin
                        err_set    = 1'b1;
                        state_next = ST_DONE;
                    end else if (!acc_cont) begin
                        state_next = ST_LITERAL;
                    end
                end else if (trunc) begin
                    err_set    = ERRCHK_EN;
                    state_next = ST_DONE;
                end
            end
            ST_LITERAL: begin
                if (acc_len == '0) begin
                    // The last sequence of a block carries literals only.
                    state_next = trunc ? ST_DONE : ST_OFF_LO;
                end else if (byte_avail) begin
                    lit_valid = 1'b1;
                    if (lit_ready) begin
                        consume = 1'b1;
                        acc_dec = 1'b1;
                    end
                end else if (trunc) begin
                    err_set    = ERRCHK_EN;
                    state_next = ST_DONE;
                end
            end
            ST_OFF_LO: begin
                if (byte_avail) begin
                    consume     = 1'b1;
                    off_lo_load = 1'b1;
                    state_next  = ST_OFF_HI;
                end else if (trunc) begin
                    err_set    = ERRCHK_EN;
                    state_next = ST_DONE;
                end
            end
            ST_OFF_HI: begin
                if (byte_avail) begin
                    consume     = 1'b1;
                    off_hi_load = 1'b1;
                    if (ERRCHK_EN && (byte_cur == '0) && (off_lo_reg == '0)) begin
                        err_set    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        acc_load   = 1'b1;
                        acc_nib    = mnib_reg;
                        state_next = (mnib_reg == LZ4_NIB_EXT) ? ST_MLEN_EXT : ST_MATCH;
                    end
                end else if (trunc) begin
                    err_set    = ERRCHK_EN;
                    state_next = ST_DONE;
                end
            end
            ST_MLEN_EXT: begin
                if (byte_avail) begin
                    consume = 1'b1;
                    acc_add = 1'b1;
                    if (ERRCHK_EN && acc_carry) begin
                        err_set    = 1'b1;
                        state_next = ST_DONE;
                    end else if (!acc_cont) begin
                        state_next = ST_MATCH;
                    end
                end else if (trunc) begin
                    err_set    = ERRCHK_EN;
                    state_next = ST_DONE;
                end
            end
            ST_MATCH: begin
                // Adding MINMATCH can still overflow a near-full length.
                if (ERRCHK_EN && mlen_sum[LEN_W]) begin
                    err_set    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    match_valid = 1'b1;
                    if (match_ready) begin
                        state_next = ((remaining_reg != '0) || byte_avail) ? ST_TOKEN : ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                blk_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            remaining_reg  <= '0;
            rd_pend_reg    <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            off_lo_reg     <= '0;
            off_hi_reg     <= '0;
            mnib_reg       <= 4'd0;
            err_reg        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_pend_reg <= in_rd;
            if ((state_reg == ST_IDLE) && blk_start) begin
                remaining_reg <= blk_len;
                err_reg       <= 1'b0;
            end else if (in_rd) begin
                remaining_reg <= remaining_reg - {{(LEN_W - 1){1'b0}}, 1'b1};
            end
            if (err_set) err_reg <= 1'b1;
            // Leftover bytes of an aborted block are discarded.
            if ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) begin
                hold_valid_reg <= 1'b0;
            end else if (rd_pend_reg && !consume) begin
                hold_valid_reg <= 1'b1;
                hold_data_reg  <= in_data;
            end else if (consume) begin
                hold_valid_reg <= 1'b0;
            end
            if (off_lo_load) off_lo_reg <= byte_cur;
            if (off_hi_load) off_hi_reg <= byte_cur;
            if (mnib_load)   mnib_reg   <= byte_cur[3:0];
        end
    end

`ifdef LZ4_PARSE_ERRCHK_EN
    assign err = err_reg;
`else
    logic unused_err;
    assign err        = 1'b0;
    assign unused_err = err_reg;
`endif

endmodule

// File: tb/tb_lz4_seq_parser.sv
// ---------------------------------------------------------------------------
// tb_lz4_seq_parser
// Self-checking bench: a byte-buffer model feeds the parser, expected
// literals/matches are queued per stream and compared as the DUT emits them.
// ---------------------------------------------------------------------------
module tb_lz4_seq_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blk_start = 1'b0;
    logic [15:0] blk_len = 16'd0;
    logic [7:0]  in_data = 8'd0;
    logic        in_exists = 1'b0;
    logic        in_rd;
    logic        lit_valid;
    logic [7:0]  lit_data;
    logic        lit_ready = 1'b0;
    logic        match_valid;
    logic [15:0] match_off;
    logic [15:0] match_len;
    logic        match_ready = 1'b0;
    logic        busy;
    logic        blk_done;
    logic        err;

    lz4_seq_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .blk_start   (blk_start),
        .blk_len     (blk_len),
        .in_data     (in_data),
        .in_exists   (in_exists),
        .in_rd       (in_rd),
        .lit_valid   (lit_valid),
        .lit_data    (lit_data),
        .lit_ready   (lit_ready),
        .match_valid (match_valid),
        .match_off   (match_off),
        .match_len   (match_len),
        .match_ready (match_ready),
        .busy        (busy),
        .blk_done    (blk_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_match;
        logic [7:0]  lit;
        logic [15:0] off;
        logic [15:0] len;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] in_buf[$];
    exp_t       e;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;
    bit rand_mode = 1'b0;
    bit hold_lit = 1'b0;
    bit gap;
    bit rd_req = 1'b0;
    logic [7:0]  next_byte = 8'd0;
    bit          prev_lit_stall = 1'b0;
    logic [7:0]  prev_lit_data;
    bit          prev_match_stall = 1'b0;
    logic [15:0] prev_off, prev_len;

    // Buffer model and output monitor: inputs change on the falling edge,
    // outputs are sampled 1 time unit later.
    always @(negedge clk) begin
        if (rand_mode) begin
            lit_ready   = ($urandom_range(0, 1) == 1);
            match_ready = ($urandom_range(0, 1) == 1);
            gap         = ($urandom_range(0, 3) == 0);
        end else begin
            lit_ready   = 1'b1;
            match_ready = 1'b1;
            gap         = 1'b0;
        end
        if (hold_lit) lit_ready = 1'b0;
        in_exists = !gap && (in_buf.size() > 0);
        #1;
        if (mon_en) begin
            if (in_rd) begin
                checks++;
                if (!in_exists) begin
                    errors++;
                    $display("FAIL rd_protocol: in_rd=1 while in_exists=%0b, required in_exists=1", in_exists);
                end
            end
            if (lit_valid || match_valid) begin
                checks++;
                if (lit_valid && match_valid) begin
                    errors++;
                    $display("FAIL exclusive_valid: lit_valid=%0b match_valid=%0b, required not both", lit_valid, match_valid);
                end
            end
            if (prev_lit_stall) begin
                checks++;
                if (!lit_valid || lit_data !== prev_lit_data) begin
                    errors++;
                    $display("FAIL lit_stable: valid=%0b data=0x%02h, required valid=1 data=0x%02h", lit_valid, lit_data, prev_lit_data);
                end
            end
            if (prev_match_stall) begin
                checks++;
                if (!match_valid || match_off !== prev_off || match_len !== prev_len) begin
                    errors++;
                    $display("FAIL match_stable: valid=%0b off=%0d len=%0d, required valid=1 off=%0d len=%0d", match_valid, match_off, match_len, prev_off, prev_len);
                end
            end
            if (lit_valid && lit_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL lit_beat: got lit 0x%02h, required no output", lit_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_match || lit_data !== e.lit) begin
                        errors++;
                        $display("FAIL lit_beat: got lit 0x%02h, required is_match=%0b lit=0x%02h off=%0d len=%0d", lit_data, e.is_match, e.lit, e.off, e.len);
                    end
                end
            end
            if (match_valid && match_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL match_beat: got off=%0d len=%0d, required no output", match_off, match_len);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_match || match_off !== e.off || match_len !== e.len) begin
                        errors++;
                        $display("FAIL match_beat: got off=%0d len=%0d, required is_match=%0b lit=0x%02h off=%0d len=%0d", match_off, match_len, e.is_match, e.lit, e.off, e.len);
                    end
                end
            end
            prev_lit_stall   = lit_valid && !lit_ready;
            prev_lit_data    = lit_data;
            prev_match_stall = match_valid && !match_ready;
            prev_off         = match_off;
            prev_len         = match_len;
            if (blk_done) done_cnt++;
        end else begin
            prev_lit_stall   = 1'b0;
            prev_match_stall = 1'b0;
        end
        rd_req = in_rd;
        if (in_rd) begin
            rd_cnt++;
            if (in_buf.size() > 0) next_byte = in_buf.pop_front();
        end
    end

    // Read data becomes visible in the cycle after the request.
    always @(posedge clk) begin
        #1;
        if (rd_req) in_data = next_byte;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    task automatic push_lit(input logic [7:0] b);
        exp_t x;
        x.is_match = 1'b0; x.lit = b; x.off = 16'd0; x.len = 16'd0;
        exp_q.push_back(x);
    endtask

    task automatic push_match(input logic [15:0] o, input logic [15:0] l);
        exp_t x;
        x.is_match = 1'b1; x.lit = 8'd0; x.off = o; x.len = l;
        exp_q.push_back(x);
    endtask

    task automatic load_test1();
        logic [7:0] s[7] = '{8'h11, 8'h41, 8'h01, 8'h00, 8'h20, 8'h42, 8'h43};
        foreach (s[i]) in_buf.push_back(s[i]);
        push_lit(8'h41);
        push_match(16'd1, 16'd5);
        push_lit(8'h42);
        push_lit(8'h43);
    endtask

    task automatic start_block(input logic [15:0] len);
        @(negedge clk);
        blk_start = 1'b1;
        blk_len   = len;
        @(negedge clk);
        blk_start = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({in_rd, lit_valid, lit_data, match_valid, match_off, match_len, busy, blk_done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%0b lv=%0b ld=%02h mv=%0b mo=%0d ml=%0d busy=%0b done=%0b err=%0b, required all 0",
                     in_rd, lit_valid, lit_data, match_valid, match_off, match_len, busy, blk_done, err);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic(input string name);
        int d0, r0;
        bit ok;
        d0 = done_cnt; r0 = rd_cnt;
        load_test1();
        start_block(16'd7);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: busy=%0b, required 1", name, busy);
        end
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s_done: blk_done pulses=%0d, required 1", name, done_cnt - d0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_outputs: %0d expected items left, required 0", name, exp_q.size());
        end
        checks++;
        if (rd_cnt - r0 != 7) begin
            errors++;
            $display("FAIL %s_reads: in_rd count=%0d, required 7", name, rd_cnt - r0);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_status: err=%0b busy=%0b, required err=0 busy=0", name, err, busy);
        end
        exp_q.delete();
        in_buf.delete();
    endtask

    task automatic test_lit_ext();
        int d0, r0;
        bit ok;
        d0 = done_cnt; r0 = rd_cnt;
        in_buf.push_back(8'hF0);
        in_buf.push_back(8'hFF);
        in_buf.push_back(8'h05);
        for (int i = 0; i < 275; i++) begin
            in_buf.push_back(8'(i * 7 + 3));
            push_lit(8'(i * 7 + 3));
        end
        start_block(16'd278);
        repeat (20) @(negedge clk);
        // A start pulse while busy must not disturb the running block.
        blk_start = 1'b1;
        blk_len   = 16'd3;
        @(negedge clk);
        blk_start = 1'b0;
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL lit_ext_done: blk_done pulses=%0d, required 1", done_cnt - d0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lit_ext_outputs: %0d of 275 literals missing, required 0", exp_q.size());
        end
        checks++;
        if (rd_cnt - r0 != 278) begin
            errors++;
            $display("FAIL lit_ext_reads: in_rd count=%0d, required 278", rd_cnt - r0);
        end
        exp_q.delete();
        in_buf.delete();
    endtask

    task automatic test_match_ext();
        int d0, r0;
        bit ok;
        logic [7:0] s[5] = '{8'h0F, 8'h02, 8'h00, 8'hFF, 8'h03};
        d0 = done_cnt; r0 = rd_cnt;
        foreach (s[i]) in_buf.push_back(s[i]);
        push_match(16'd2, 16'd277);
        start_block(16'd5);
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL match_ext: done pulses=%0d items left=%0d, required 1 and 0", done_cnt - d0, exp_q.size());
        end
        checks++;
        if (rd_cnt - r0 != 5) begin
            errors++;
            $display("FAIL match_ext_reads: in_rd count=%0d, required 5", rd_cnt - r0);
        end
        exp_q.delete();
        in_buf.delete();
    endtask

    task automatic test_empty_block();
        int r0;
        r0 = rd_cnt;
        @(negedge clk);
        blk_start = 1'b1;
        blk_len   = 16'd0;
        @(negedge clk);
        blk_start = 1'b0;
        #2;
        checks++;
        if (blk_done !== 1'b0) begin
            errors++;
            $display("FAIL empty_early: blk_done=%0b one cycle after start, required 0", blk_done);
        end
        @(negedge clk);
        #2;
        checks++;
        if (blk_done !== 1'b1) begin
            errors++;
            $display("FAIL empty_done: blk_done=%0b two cycles after start, required 1", blk_done);
        end
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (rd_cnt - r0 != 0) begin
            errors++;
            $display("FAIL empty_reads: in_rd count=%0d, required 0", rd_cnt - r0);
        end
    endtask

    task automatic test_offset_zero();
        int d0;
        bit ok;
        logic exp_err;
        d0 = done_cnt;
        in_buf.push_back(8'h00);
        in_buf.push_back(8'h00);
        in_buf.push_back(8'h00);
`ifdef LZ4_PARSE_ERRCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
        push_match(16'd0, 16'd4);
`endif
        start_block(16'd3);
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL offset_zero: done pulses=%0d items left=%0d, required 1 and 0", done_cnt - d0, exp_q.size());
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL offset_zero_err: err=%0b, required %0b", err, exp_err);
        end
        exp_q.delete();
        in_buf.delete();
    endtask

    task automatic test_truncation();
        int d0;
        bit ok;
        logic exp_err;
        d0 = done_cnt;
        in_buf.push_back(8'h11);
        in_buf.push_back(8'h41);
        in_buf.push_back(8'h01);
        push_lit(8'h41);
`ifdef LZ4_PARSE_ERRCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        start_block(16'd3);
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL truncation: done pulses=%0d items left=%0d, required 1 and 0", done_cnt - d0, exp_q.size());
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL truncation_err: err=%0b, required %0b", err, exp_err);
        end
        exp_q.delete();
        in_buf.delete();
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_test1();
        hold_lit = 1'b1;
        start_block(16'd7);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (lit_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_literal: lit_valid never seen, required 1");
        end
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        checks++;
        if ({in_rd, lit_valid, lit_data, match_valid, match_off, match_len, busy, blk_done, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: rd=%0b lv=%0b ld=%02h mv=%0b mo=%0d ml=%0d busy=%0b done=%0b err=%0b, required all 0",
                     in_rd, lit_valid, lit_data, match_valid, match_off, match_len, busy, blk_done, err);
        end
        rst_n    = 1'b1;
        hold_lit = 1'b0;
        exp_q.delete();
        in_buf.delete();
        @(negedge clk);
        mon_en = 1'b1;
        test_basic("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_lit_ext();
        test_match_ext();
        test_empty_block();
        rand_mode = 1'b1;
        for (int k = 0; k < 4; k++) test_basic("stall");
        rand_mode = 1'b0;
        test_offset_zero();
        test_truncation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lz4_seq_parser.md
Name: lz4_seq_parser

Overview:
- Consumes the byte stream held by the upstream compressed-data input buffer and decodes LZ4 block sequences.
- Each sequence is: token, optional literal-length extension bytes, literal bytes, 2-byte little-endian offset, optional match-length extension bytes.
- Emits a literal byte stream and match commands (offset, length) to the downstream copy/history stage.
- One block per start pulse; the block ends when blk_len bytes have been consumed.

Parameters:
- WORD_W, 8, byte width; fixed at 8 for LZ4.
- LEN_W, 16, width of literal/match length counters and of blk_len.
- OFF_W, 16, match offset width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- blk_start  in  1  one-cycle pulse; accepted only in IDLE
- blk_len  in  LEN_W  compressed block length in bytes; sampled on blk_start
- in_data  in  WORD_W  byte from input buffer; valid the cycle after in_rd
- in_exists  in  1  input buffer holds unread data
- in_rd  out  1  read request; asserted only while in_exists=1
- lit_valid  out  1  lit_data valid
- lit_data  out  WORD_W  literal byte
- lit_ready  in  1  downstream accepts literal
- match_valid  out  1  match command valid
- match_off  out  OFF_W  match offset
- match_len  out  LEN_W  total match length (includes MINMATCH)
- match_ready  in  1  downstream accepts match
- busy  out  1  high from accepted blk_start until blk_done
- blk_done  out  1  one-cycle pulse when block completes
- err  out  1  sticky error flag; cleared by reset or next blk_start

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; counters 0; no read in flight. Reset mid-block abandons the block; the input buffer is not rewound.
- Read protocol:
  - At most one read in flight.
  - in_rd is issued in cycle N only if in_exists=1, the byte holding register is empty, and remaining>0.
  - in_data is captured into the holding register in cycle N+1.
  - remaining is decremented on each issued read.
- Throughput: a read may be issued in the same cycle the held byte is consumed, giving one byte per cycle sustained.
- States:
  - IDLE: wait for blk_start; load remaining=blk_len.
  - TOKEN: consume byte; lit_len=tok[7:4]; mlen_nib=tok[3:0]. If tok[7:4]==15 go to LIT_EXT, else if lit_len>0 go to LITERAL, else go to OFF_LO.
  - LIT_EXT: add each byte to lit_len; stay while byte==255; then go to LITERAL.
  - LITERAL: present the held byte on lit_valid/lit_data; consume on lit_valid&&lit_ready; decrement lit_len. At 0: if remaining==0 and no byte held, go to DONE, else go to OFF_LO.
  - OFF_LO / OFF_HI: assemble match_off = {hi, lo}.
  - MLEN_EXT: entered from OFF_HI when mlen_nib==15; add bytes while byte==255.
  - MATCH: match_valid=1, match_len=mlen+4; held until match_ready; then go to TOKEN if remaining>0 or a byte is held, else DONE.
  - DONE: pulse blk_done for one cycle; go to IDLE.
- Block end after TOKEN with lit_len==0 and remaining==0 goes to DONE.
- Block exhaustion in OFF_LO, OFF_HI, LIT_EXT or MLEN_EXT is a truncation error.
- lit_valid and match_valid are never high together; data is held stable while valid && !ready.
- Length arithmetic is LEN_W wide and saturates at all-ones.
- blk_start while busy is ignored.
- blk_len=0 gives blk_done two cycles after blk_start and no reads.
- in_exists dropping mid-field stalls the FSM in its current state; there is no timeout.

Optional Feature:
- Macro: LZ4_PARSE_ERRCHK_EN
- Defined:
  - err is set on offset==0, on length saturation, or on truncation.
  - On error: go to DONE immediately, pulse blk_done, and emit no further outputs for the block.
- Undefined:
  - err is tied to 0.
  - Truncation forces DONE; offset 0 is passed through.
  - Lengths wrap instead of saturating.

Decomposition:
- Package lz4_pkg: state enum, LZ4_MINMATCH=4, LZ4_NIB_EXT=15, LZ4_EXT_CONT=255, and default width constants.
- Sub-module lz4_len_accum: loads nibble, adds extension bytes, saturates, and reports continue (byte==255). Instantiated once and shared by the literal and match length fields, since they are never active simultaneously.

Test Plan:
- Bytes 11 41 01 00 20 42 43, blk_len=7, ready held high:
  - lit 0x41; match off=1 len=5; lit 0x42, 0x43; blk_done once; 7 in_rd total.
- Token F0, ext FF 05, then 275 literals, blk_len=278:
  - 275 lit beats, no match, blk_done.
- Token 0F, then 02 00 FF 03:
  - match off=2 len=4+15+255+3=277.
- Same stream as test 1 with lit_ready/match_ready toggled randomly and in_exists gapped:
  - identical output sequence; data stable while stalled; no in_rd when in_exists=0.
- Offset 00 00 with LZ4_PARSE_ERRCHK_EN:
  - err=1, no match_valid, blk_done.
  - Without the macro: match off=0 emitted.
- rst_n low in LITERAL mid-block:
  - next cycle all outputs 0, IDLE.
  - A new blk_start then parses correctly.
